// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch vs. data access) in front of a single
// fixed-latency memory port. Ties alternate, so neither side can starve.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 3,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,

  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,

  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,

  output logic              delay
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_IF,
    SERVE_MEM
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                last_if_q, last_if_d;
  logic                if_ready_q, if_ready_d;
  logic                mem_ready_q, mem_ready_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;

  logic                if_elig;
  logic                mem_elig;
  logic                grant_if;
  logic                grant_mem;
  logic                done;

  // A side still showing its ready pulse has just been served and must not
  // immediately win again off its still-held request.
  always_comb begin
    if_elig   = if_req  & ~if_ready_q;
    mem_elig  = mem_req & ~mem_ready_q;
    grant_mem = mem_elig & (~if_elig | last_if_q);
    grant_if  = if_elig & ~grant_mem;
    done      = (state_q != IDLE) && (cnt_q == '0);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d = SERVE_MEM;
        end else if (grant_if) begin
          state_d = SERVE_IF;
        end
      end
      SERVE_IF,
      SERVE_MEM: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: transfer latch, counter, grant history, responses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      last_if_q   <= 1'b1;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      last_if_q   <= last_if_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    last_if_d   = last_if_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    if (state_q == IDLE) begin
      if (grant_mem) begin
        addr_d    = mem_addr;
        we_d      = mem_we;
        wdata_d   = mem_wdata;
        cnt_d     = CNT_LOAD;
        last_if_d = 1'b0;
      end else if (grant_if) begin
        addr_d    = if_addr;
        we_d      = 1'b0;
        wdata_d   = '0;
        cnt_d     = CNT_LOAD;
        last_if_d = 1'b1;
      end
    end else if (done) begin
      if (state_q == SERVE_IF) begin
        if_ready_d = 1'b1;
        if_rdata_d = ram_rdata;
      end else begin
        mem_ready_d = 1'b1;
        if (!we_q) begin
          mem_rdata_d = ram_rdata;
        end
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Output logic: memory port is driven only while a transfer is in flight
  always_comb begin
    ram_en    = (state_q != IDLE);
    ram_we    = (state_q == SERVE_MEM) & we_q;
    ram_addr  = (state_q != IDLE) ? addr_q : '0;
    ram_wdata = (state_q == SERVE_MEM) ? wdata_q : '0;

    if_ready  = if_ready_q;
    mem_ready = mem_ready_q;
    if_rdata  = if_rdata_q;
    mem_rdata = mem_rdata_q;

    delay     = (if_req & ~if_ready_q) | (mem_req & ~mem_ready_q);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus queues expected memory
// beats and ready pulses (with cycle numbers); a negedge monitor checks them.
module tb_mem_arbiter;

  localparam int MEM_LAT = 3;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        delay;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .delay     (delay)
  );

  // Memory contents: word at address a reads as A5A5_0000 | (a >> 4)
  always_comb ram_rdata = 32'hA5A5_0000 | (ram_addr >> 4);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wd;
  } beat_t;

  typedef struct {
    int          cyc;
    bit          is_mem;
    logic [31:0] data;
  } rdy_t;

  beat_t beat_q[$];
  rdy_t  rdy_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_beats(input int start, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input bit chk_wd);
    for (int i = 1; i <= MEM_LAT; i++) beat_q.push_back('{start + i, we, addr, wd, chk_wd});
  endtask

  task automatic push_rdy(input int c, input bit is_mem, input logic [31:0] data);
    rdy_q.push_back('{c, is_mem, data});
  endtask

  // Monitor
  always @(negedge clk) begin
    beat_t b;
    rdy_t  r;
    if (ram_en) begin
      if (beat_q.size() == 0) begin
        chk("unexpected_ram_beat", 64'(ram_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        b = beat_q.pop_front();
        chk("beat_cycle", 64'(cyc), 64'(b.cyc));
        chk("beat_addr", 64'(ram_addr), 64'(b.addr));
        chk("beat_we", 64'(ram_we), 64'(b.we));
        if (b.chk_wd) chk("beat_wdata", 64'(ram_wdata), 64'(b.wdata));
      end
    end else begin
      chk("idle_ram_outputs_zero", {31'd0, ram_we, ram_addr}, 64'd0);
      chk("idle_ram_wdata_zero", 64'(ram_wdata), 64'd0);
    end
    if (if_ready) begin
      if (rdy_q.size() == 0) begin
        chk("unexpected_if_ready", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        r = rdy_q.pop_front();
        chk("if_ready_side", 64'(0), 64'(r.is_mem));
        chk("if_ready_cycle", 64'(cyc), 64'(r.cyc));
        chk("if_rdata", 64'(if_rdata), 64'(r.data));
      end
    end
    if (mem_ready) begin
      if (rdy_q.size() == 0) begin
        chk("unexpected_mem_ready", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        r = rdy_q.pop_front();
        chk("mem_ready_side", 64'(1), 64'(r.is_mem));
        chk("mem_ready_cycle", 64'(cyc), 64'(r.cyc));
        chk("mem_rdata", 64'(mem_rdata), 64'(r.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int r0;

    reset     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Asynchronous reset with no clock edge yet
    #1 reset = 1'b1;
    #1;
    chk("rst_if_ready", 64'(if_ready), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    chk("rst_if_rdata", 64'(if_rdata), 64'd0);
    chk("rst_mem_rdata", 64'(mem_rdata), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    chk("rst_delay_idle", 64'(delay), 64'd0);
    if_req = 1'b1;
    #1 chk("rst_delay_if_req", 64'(delay), 64'd1);
    if_req  = 1'b0;
    mem_req = 1'b1;
    #1 chk("rst_delay_mem_req", 64'(delay), 64'd1);
    mem_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single fetch, address changed mid-transfer
    t0 = cyc;
    if_req  = 1'b1;
    if_addr = 32'h10;
    push_beats(t0, 1'b0, 32'h10, 32'h0, 1'b0);
    push_rdy(t0 + 4, 1'b0, 32'hA5A5_0001);
    #1 chk("fetch_delay_c0", 64'(delay), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("fetch_delay", 64'(delay), (k < 4) ? 64'd1 : 64'd0);
      if (k == 2) if_addr = 32'h44;
    end
    if_req  = 1'b0;
    if_addr = '0;

    // Tie right after reset: MEM first, then IF
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    t0 = cyc;
    if_req   = 1'b1;
    if_addr  = 32'h100;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h200;
    push_beats(t0, 1'b0, 32'h200, 32'h0, 1'b0);
    push_rdy(t0 + 4, 1'b1, 32'hA5A5_0020);
    push_beats(t0 + 4, 1'b0, 32'h100, 32'h0, 1'b0);
    push_rdy(t0 + 8, 1'b0, 32'hA5A5_0010);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) mem_req = 1'b0;
      if (k == 8) if_req = 1'b0;
    end

    // Both held continuously: MEM, IF, MEM, IF
    @(negedge clk);
    t0 = cyc;
    if_req   = 1'b1;
    if_addr  = 32'h300;
    mem_req  = 1'b1;
    mem_addr = 32'h400;
    push_beats(t0, 1'b0, 32'h400, 32'h0, 1'b0);
    push_rdy(t0 + 4, 1'b1, 32'hA5A5_0040);
    push_beats(t0 + 4, 1'b0, 32'h300, 32'h0, 1'b0);
    push_rdy(t0 + 8, 1'b0, 32'hA5A5_0030);
    push_beats(t0 + 8, 1'b0, 32'h410, 32'h0, 1'b0);
    push_rdy(t0 + 12, 1'b1, 32'hA5A5_0041);
    push_beats(t0 + 12, 1'b0, 32'h310, 32'h0, 1'b0);
    push_rdy(t0 + 16, 1'b0, 32'hA5A5_0031);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 4)  mem_addr = 32'h410;
      if (k == 8)  if_addr = 32'h310;
      if (k == 12) mem_req = 1'b0;
      if (k == 16) if_req = 1'b0;
    end

    // Data write: mem_rdata keeps the last read value, wdata change ignored
    @(negedge clk);
    t0 = cyc;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h20;
    mem_wdata = 32'hDEAD_BEEF;
    push_beats(t0, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b1);
    push_rdy(t0 + 4, 1'b1, 32'hA5A5_0041);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2) mem_wdata = 32'h1234_5678;
    end
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;

    // Reset in cycle 2 of a fetch, request held through release
    @(negedge clk);
    t0 = cyc;
    if_req  = 1'b1;
    if_addr = 32'h50;
    beat_q.push_back('{t0 + 1, 1'b0, 32'h50, 32'h0, 1'b0});
    beat_q.push_back('{t0 + 2, 1'b0, 32'h50, 32'h0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_ram_en", 64'(ram_en), 64'd0);
    chk("abort_ram_addr", 64'(ram_addr), 64'd0);
    chk("abort_if_ready", 64'(if_ready), 64'd0);
    chk("abort_if_rdata", 64'(if_rdata), 64'd0);
    chk("abort_mem_rdata", 64'(mem_rdata), 64'd0);
    chk("abort_delay", 64'(delay), 64'd1);
    @(negedge clk);
    r0 = cyc;
    reset = 1'b0;
    push_beats(r0, 1'b0, 32'h50, 32'h0, 1'b0);
    push_rdy(r0 + 4, 1'b0, 32'hA5A5_0005);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    if_req = 1'b0;

    for (int k = 0; k < 4; k++) @(negedge clk);
    chk("beats_outstanding", 64'(beat_q.size()), 64'd0);
    chk("readies_outstanding", 64'(rdy_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
